tune_req_ctrl: RTL and testbench
================================

// Module: tune_req_ctrl
// PURPOSE
//  Request sequencer directly upstream of the sponge tune player. Collects
//  single-cycle play requests from the rest of the design (e.g. tour-complete
//  and error events), queues them as a pending count, and issues one-cycle go
//  pulses to sponge one tune at a time. Waits for sponge's done, then enforces
//  a silent gap before the next tune. A watchdog recovers if done never arrives.
// PARAMETERS
//  FAST_SIM  0  1: shrink GAP/TMO counts for simulation (matches sponge FAST_SIM)
//  DEPTH     4  max pending requests, 1..15
//  GAP       FAST_SIM ? 16 : 2_500_000     inter-tune silence, clk cycles
//  TMO       FAST_SIM ? 4096 : 2**27       max PLAY duration before forced exit
// PORTS
//  clk      in   1   system clock
//  rst_n    in   1   async reset, active low
//  req      in   1   play request, one-cycle pulse (level held = one req/cycle)
//  cancel   in   1   flush all pending requests (does not stop current tune)
//  clr_err  in   1   clear sticky ovf and tmo flags
//  done     in   1   from sponge; tune finished (rising edge is the event)
//  go       out  1   to sponge; one-cycle start pulse
//  busy     out  1   high in LAUNCH, PLAY, GAP
//  pend     out  4   pending request count, 0..DEPTH
//  ovf      out  1   sticky: request dropped because pend==DEPTH
//  tmo      out  1   sticky: watchdog fired in PLAY
// BEHAVIOUR
//  Reset: state=IDLE; go=0, busy=0, pend=0, ovf=0, tmo=0; gap/tmo counters 0,
//   done edge-detect register 0. Reset mid-tune returns to IDLE. sponge shares
//   rst_n, so no stale done is expected.
//  All outputs registered. done rising edge via registered prior value (done_q).
//  Pend update per cycle: +1 if req && pend<DEPTH; -1 on launch; both -> hold.
//   req && pend==DEPTH && !launch -> drop, ovf<=1. cancel has priority over req
//   and launch: pend<=0 and no launch that cycle.
//  States:
//   IDLE   : busy=0. If pend>0 && !cancel -> LAUNCH, pend-1.
//   LAUNCH : go=1 for exactly this one cycle; tmo counter cleared -> PLAY.
//   PLAY   : tmo counter +1/cycle. done rise -> GAP. counter==TMO-1 without
//            done -> tmo<=1, GAP. done rise and timeout in same cycle -> GAP,
//            tmo not set.
//   GAP    : gap counter 0..GAP-1, then IDLE. done rises here are ignored.
//  Latency: req sampled at edge k in IDLE with pend=0 -> pend=1 after k,
//   LAUNCH after k+1 (go high one cycle), PLAY after k+2.
//   Back-to-back tunes: go pulses separated by >= tune length + GAP + 2.
//  go is never asserted outside LAUNCH. Never two go pulses without an
//   intervening done or timeout.
//  clr_err clears ovf/tmo the next edge. A same-cycle set event wins over clear.
//  Counters sized for max(GAP,TMO) and saturate-free by construction. pend
//   never wraps in either direction.
// TESTING
//  1 req pulse, FAST_SIM=1, sponge stub done 200 cycles after go -> one go
//    pulse 2 cycles after req; busy high through PLAY+16 GAP cycles; pend 0.
//  2 6 req pulses back-to-back with DEPTH=4 while idle -> first launches,
//    pend peaks at 4, ovf=1, exactly 5 go pulses total, each after GAP.
//  3 req + launch in the same cycle (pend=1 in IDLE, req asserted) -> pend stays 1.
//  4 stub never asserts done -> tmo=1 after 4096 PLAY cycles, GAP, next
//    pending req launches. clr_err -> tmo=0.
//  5 cancel during PLAY with pend=3 -> pend=0, current tune completes, no go.
//  6 rst_n low mid-PLAY -> all outputs 0 asynchronously, IDLE. Release + req
//    -> normal launch.

Source files
------------

// File: rtl/tune_req_if.sv
// ---------------------------------------------------------------------------
// tune_req_if
//   Handshake bundle between the request sources, the sponge tune player and
//   the tune request sequencer (tune_req_ctrl).
//
//   req      play request, one-cycle pulse (held high = one request per cycle)
//   cancel   flush every pending request (the tune already playing continues)
//   clr_err  clear the sticky ovf/tmo flags
//   done     from sponge: tune finished, the rising edge is the event
//   go       to sponge: one-cycle start pulse
//   busy     sequencer is launching, playing or holding the inter-tune gap
//   pend     number of queued requests, 0..DEPTH
//   ovf      sticky: a request was dropped because the queue was full
//   tmo      sticky: the watchdog ended a tune that never reported done
//
//   master : the side that drives requests and done (system / testbench)
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface tune_req_if;
  logic       req;
  logic       cancel;
  logic       clr_err;
  logic       done;
  logic       go;
  logic       busy;
  logic [3:0] pend;
  logic       ovf;
  logic       tmo;

  modport master (
    output req, cancel, clr_err, done,
    input  go, busy, pend, ovf, tmo
  );

  modport slave (
    input  req, cancel, clr_err, done,
    output go, busy, pend, ovf, tmo
  );
endinterface

// File: rtl/tune_req_ctrl.sv
// ---------------------------------------------------------------------------
// tune_req_ctrl
//   Request sequencer sitting directly upstream of the sponge tune player.
//   Single-cycle play requests are counted into a small pending queue. One
//   tune at a time is started with a one-cycle go pulse; the sequencer then
//   waits for the rising edge of sponge's done, holds a silent gap, and only
//   then considers the next pending request. A watchdog ends a tune whose
//   done never arrives and raises the sticky tmo flag.
//
// Parameters
//   FAST_SIM  1 shrinks GAP/TMO for simulation (matches sponge FAST_SIM)
//   DEPTH     maximum number of pending requests, 1..15
//   GAP       inter-tune silence in clk cycles
//   TMO       maximum PLAY duration in clk cycles before a forced exit
//
// Ports
//   clk      system clock
//   rst_n    asynchronous reset, active low (shared with sponge)
//   bus      tune_req_if.slave: req/cancel/clr_err/done in,
//            go/busy/pend/ovf/tmo out, all outputs registered
//
// Sequence
//   IDLE -> LAUNCH (go high for this one cycle) -> PLAY -> GAP -> IDLE
//   A request seen in IDLE with an empty queue gives pend=1 after that edge,
//   LAUNCH after the next edge and PLAY after the one following.
// ---------------------------------------------------------------------------
module tune_req_ctrl #(
  parameter bit FAST_SIM = 1'b0,
  parameter int DEPTH    = 4,
  parameter int GAP      = FAST_SIM ? 16   : 2_500_000,
  parameter int TMO      = FAST_SIM ? 4096 : 2**27
) (
  input  logic       clk,
  input  logic       rst_n,
  tune_req_if.slave  bus
);

  // One counter serves both the PLAY watchdog and the GAP timer: the two
  // phases never overlap, and the counter restarts from zero on entry to
  // each. It is wide enough to reach max(GAP, TMO) - 1 without wrapping.
  localparam int CNT_MAX = (GAP > TMO) ? GAP : TMO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO - 1);
  localparam logic [3:0]       DEPTH_MAX = 4'(DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             done_q;

  logic             go_q, busy_q, ovf_q, tmo_q;
  logic [3:0]       pend_q, pend_d;

  logic             done_rise;
  logic             launch;
  logic             tmo_fire;
  logic             accept;
  logic             ovf_set;

  // sponge shares rst_n, so done_q starting at 0 cannot fake an edge.
  assign done_rise = bus.done & ~done_q;

  // -------------------------------------------------------------------------
  // Sequencer next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    launch   = 1'b0;
    tmo_fire = 1'b0;

    case (state)
      S_IDLE: begin
        // cancel flushes the queue this cycle, so it also blocks a launch.
        if ((pend_q != 4'd0) && !bus.cancel) begin
          launch  = 1'b1;
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_PLAY;
      end

      S_PLAY: begin
        // A done edge in the very cycle the watchdog expires is a normal
        // finish: the tune did complete, so tmo stays clear.
        if (done_rise) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt == TMO_LAST) begin
          tmo_fire = 1'b1;
          cnt_d    = '0;
          state_d  = S_GAP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      S_GAP: begin
        // done edges arriving here belong to the finished tune and are ignored.
        if (cnt == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Pending request count
  // -------------------------------------------------------------------------
  // A request at a full queue still fits when a launch frees a slot in the
  // same cycle. cancel overrides both requests and launches.
  always_comb begin
    accept  = bus.req && ((pend_q < DEPTH_MAX) || launch);
    ovf_set = bus.req && !accept && !bus.cancel;
    pend_d  = pend_q;

    if (bus.cancel) begin
      pend_d = 4'd0;
    end else if (accept && !launch) begin
      pend_d = pend_q + 4'd1;
    end else if (launch && !accept) begin
      pend_d = pend_q - 4'd1;
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      go_q   <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= 4'd0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      done_q <= bus.done;
      pend_q <= pend_d;

      // Outputs follow the state being entered so they line up with it.
      go_q   <= (state_d == S_LAUNCH);
      busy_q <= (state_d != S_IDLE);

      // A set event in the same cycle as clr_err wins.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clr_err) begin
        ovf_q <= 1'b0;
      end

      if (tmo_fire) begin
        tmo_q <= 1'b1;
      end else if (bus.clr_err) begin
        tmo_q <= 1'b0;
      end
    end
  end

  assign bus.go   = go_q;
  assign bus.busy = busy_q;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_q;
  assign bus.tmo  = tmo_q;

endmodule

// File: tb/tb_tune_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tune_req_ctrl
//   Directed bench for tune_req_ctrl (FAST_SIM=1, DEPTH=4).
//   A timeline model tracks, in edge numbers, when a tune was launched, when
//   its PLAY phase began and from which edge the sequencer is free again; the
//   expected outputs of every cycle follow from those times. A sponge stub
//   raises done a programmable number of cycles after each go.
// ---------------------------------------------------------------------------
module tb_tune_req_ctrl;

  localparam int DEPTH = 4;
  localparam int GAP   = 16;
  localparam int TMO   = 4096;
  localparam int NEVER = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tune_req_if bus ();

  tune_req_ctrl #(
    .FAST_SIM (1'b1),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Timeline model, advanced on every clock edge / reset assertion
  // -------------------------------------------------------------------------
  int ev        = 0;        // event (edge) number
  int free_at   = 0;        // first edge after which the sequencer is idle
  int go_edge   = -100;     // edge after which go is high
  int play_from = 0;        // edge after which the first PLAY cycle runs
  bit in_play   = 1'b0;
  int m_pend    = 0;
  bit m_ovf     = 1'b0;
  bit m_tmo     = 1'b0;
  bit done_prev = 1'b0;
  bit exp_go    = 1'b0;
  bit exp_busy  = 1'b0;

  initial begin
    bit launch, rise, acc, oset, tset;
    int played;
    forever begin
      @(posedge clk or negedge rst_n);
      ev++;
      if (!rst_n) begin
        free_at   = ev;
        go_edge   = -100;
        in_play   = 1'b0;
        m_pend    = 0;
        m_ovf     = 1'b0;
        m_tmo     = 1'b0;
        done_prev = 1'b0;
      end else begin
        launch = (ev - 1 >= free_at) && (m_pend > 0) && !bus.cancel;
        rise   = bus.done && !done_prev;
        tset   = 1'b0;
        if (in_play && (ev - 1 >= play_from)) begin
          played = ev - play_from;   // PLAY cycles completed so far
          if (rise) begin
            in_play = 1'b0;
            free_at = ev + GAP;
          end else if (played == TMO) begin
            in_play = 1'b0;
            free_at = ev + GAP;
            tset    = 1'b1;
          end
        end
        if (bus.cancel) begin
          m_pend = 0;
          oset   = 1'b0;
        end else begin
          acc    = bus.req && ((m_pend < DEPTH) || launch);
          oset   = bus.req && !acc;
          m_pend = m_pend + int'(acc) - int'(launch);
        end
        if (oset) m_ovf = 1'b1;
        else if (bus.clr_err) m_ovf = 1'b0;
        if (tset) m_tmo = 1'b1;
        else if (bus.clr_err) m_tmo = 1'b0;
        if (launch) begin
          go_edge   = ev;
          play_from = ev + 1;
          in_play   = 1'b1;
          free_at   = NEVER;
        end
        done_prev = bus.done;
      end
      exp_go   = (ev == go_edge);
      exp_busy = (ev < free_at);
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare, on the falling edge
  // -------------------------------------------------------------------------
  int ncyc     = 0;
  int go_count = 0;
  int go_times[$];

  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n) begin
        check("go",   {31'd0, bus.go},   {31'd0, exp_go});
        check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
        check("pend", {28'd0, bus.pend}, m_pend);
        check("ovf",  {31'd0, bus.ovf},  {31'd0, m_ovf});
        check("tmo",  {31'd0, bus.tmo},  {31'd0, m_tmo});
        if (bus.go) begin
          go_count++;
          go_times.push_back(ncyc);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // sponge stub: done goes high stub_delay cycles after go, for two cycles
  // -------------------------------------------------------------------------
  int stub_delay = 200;   // negative: never answer

  initial begin
    int cnt  = -1;
    int hold = 0;
    bus.done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.done = 1'b0;
        cnt      = -1;
        hold     = 0;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) bus.done = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.done = 1'b1;
            hold     = 2;
            cnt      = -1;
          end
        end
        if (bus.go && stub_delay >= 0) cnt = stub_delay;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (inputs change just after the falling edge)
  // -------------------------------------------------------------------------
  task automatic step(input int k = 1);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic req_burst(input int k);
    bus.req = 1'b1;
    step(k);
    bus.req = 1'b0;
  endtask

  task automatic wait_go(input string name, input int budget);
    for (int i = 0; i < budget && !bus.go; i++) step();
    check(name, {31'd0, bus.go}, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && bus.busy; i++) step();
    check(name, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------------
  // Directed tests
  // -------------------------------------------------------------------------
  initial begin
    int g0, bl, sz;
    bus.req     = 1'b0;
    bus.cancel  = 1'b0;
    bus.clr_err = 1'b0;

    step(3);
    rst_n = 1'b1;
    step();
    check("reset_go",   {31'd0, bus.go},   32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_pend", {28'd0, bus.pend}, 32'd0);
    check("reset_flags", {30'd0, bus.ovf, bus.tmo}, 32'd0);

    // 1: single request, done 200 cycles after go
    stub_delay = 200;
    g0 = go_count;
    req_burst(1);
    check("t1_pend_after_req", {28'd0, bus.pend}, 32'd1);
    check("t1_no_go_yet",      {31'd0, bus.go},   32'd0);
    step();
    check("t1_go_2_after_req", {31'd0, bus.go},   32'd1);
    check("t1_pend_launched",  {28'd0, bus.pend}, 32'd0);
    bl = 0;
    for (int i = 0; i < 1000 && bus.busy; i++) begin
      bl++;
      step();
    end
    check("t1_busy_len", bl, 32'd217);   // LAUNCH + 200 PLAY + 16 GAP
    check("t1_go_count", go_count - g0, 32'd1);

    // 2: six back-to-back requests with DEPTH=4
    stub_delay = 20;
    g0 = go_count;
    req_burst(6);
    check("t2_pend_peak", {28'd0, bus.pend}, 32'd4);
    check("t2_ovf",       {31'd0, bus.ovf},  32'd1);
    for (int i = 0; i < 1000 && !((go_count - g0 == 5) && !bus.busy); i++) step();
    step(60);
    check("t2_go_count", go_count - g0, 32'd5);
    sz = go_times.size();
    for (int i = sz - 4; i < sz; i++)
      check("t2_go_spacing", go_times[i] - go_times[i-1], 32'd38);  // 20 + GAP + 2
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("t2_ovf_cleared", {31'd0, bus.ovf}, 32'd0);

    // 3: request in the same cycle as a launch
    stub_delay = 10;
    g0 = go_count;
    bus.req = 1'b1;
    step();
    check("t3_pend_first", {28'd0, bus.pend}, 32'd1);
    step();
    bus.req = 1'b0;
    check("t3_pend_hold", {28'd0, bus.pend}, 32'd1);
    check("t3_go",        {31'd0, bus.go},   32'd1);
    step(100);
    check("t3_go_count", go_count - g0, 32'd2);

    // 4: done never arrives -> watchdog, then the queued request launches
    stub_delay = -1;
    req_burst(1);
    step();
    check("t4_go", {31'd0, bus.go}, 32'd1);
    step();
    req_burst(1);
    check("t4_pend_queued", {28'd0, bus.pend}, 32'd1);
    for (int i = 0; i < 5000 && !bus.tmo; i++) step();
    check("t4_tmo_set", {31'd0, bus.tmo}, 32'd1);
    stub_delay = 30;
    wait_go("t4_second_go", 100);
    check("t4_go_spacing", go_times[go_times.size()-1] - go_times[go_times.size()-2], 32'd4114);
    wait_idle("t4_idle", 200);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("t4_tmo_cleared", {31'd0, bus.tmo}, 32'd0);

    // 5: cancel during PLAY with three pending requests
    stub_delay = 100;
    g0 = go_count;
    req_burst(1);
    wait_go("t5_go", 10);
    step(3);
    req_burst(3);
    check("t5_pend3", {28'd0, bus.pend}, 32'd3);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("t5_pend_flushed", {28'd0, bus.pend}, 32'd0);
    check("t5_still_busy",   {31'd0, bus.busy}, 32'd1);
    wait_idle("t5_idle", 300);
    step(40);
    check("t5_go_count", go_count - g0, 32'd1);

    // 6: asynchronous reset in the middle of PLAY
    stub_delay = 100;
    req_burst(1);
    wait_go("t6_go", 10);
    step(5);
    req_burst(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_go",   {31'd0, bus.go},   32'd0);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_pend", {28'd0, bus.pend}, 32'd0);
    check("t6_rst_flags", {30'd0, bus.ovf, bus.tmo}, 32'd0);
    step(3);
    rst_n = 1'b1;
    step();
    req_burst(1);
    check("t6_pend_after_req", {28'd0, bus.pend}, 32'd1);
    step();
    check("t6_go_after_reset", {31'd0, bus.go}, 32'd1);
    wait_idle("t6_idle", 300);
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
